// File: rtl/adder_pkg.sv
// Shared types for the multi-cycle chunked adder: controller state encoding
// and the chunk index width helper.
package adder_pkg;

   typedef enum logic [1:0] {
      ADD_ST_IDLE,
      ADD_ST_RUN,
      ADD_ST_DONE
   } adder_ctrl_state_t;

   // A single-chunk operand still needs a one-bit index register.
   function automatic int idx_width(input int chunk_num);
      return $clog2(chunk_num > 1 ? chunk_num : 2);
   endfunction

endpackage

// File: rtl/adder_xbit_serial.sv
// Combinational DATA_WIDTH adder slice with carry in and carry out; the
// controller reuses it once per chunk.
module adder_xbit_serial #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  cin,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  cout
);

   logic [DATA_WIDTH:0] total;

   assign total = {1'b0, a} + {1'b0, b} + (DATA_WIDTH+1)'(cin);
   assign sum   = total[DATA_WIDTH-1:0];
   assign cout  = total[DATA_WIDTH];

endmodule

// File: rtl/adder_xbit_multi_ctrl.sv
// Sequences one shared chunk adder over a wide operand, LSB chunk first,
// with a registered carry chain and valid/ready request/result handshakes.
module adder_xbit_multi_ctrl
   import adder_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CHUNK_NUM  = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_req_valid,
   output logic                            o_req_ready,
   input  logic [DATA_WIDTH*CHUNK_NUM-1:0] i_num_a,
   input  logic [DATA_WIDTH*CHUNK_NUM-1:0] i_num_b,
   input  logic                            i_cry,
   input  logic                            i_sub,
   output logic                            o_res_valid,
   input  logic                            i_res_ready,
   output logic [DATA_WIDTH*CHUNK_NUM-1:0] o_res,
   output logic                            o_cry,
   output logic                            o_ovf
);

   localparam int OPER_WIDTH = DATA_WIDTH * CHUNK_NUM;
   localparam int IDX_WIDTH  = idx_width(CHUNK_NUM);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CHUNK_NUM - 1);

   adder_ctrl_state_t state;
   adder_ctrl_state_t state_next;

   logic [IDX_WIDTH-1:0]  idx;
   logic                  carry;
   logic [OPER_WIDTH-1:0] a_reg;
   logic [OPER_WIDTH-1:0] b_reg;
   logic [OPER_WIDTH-1:0] res;
   logic                  cry_reg;
   logic                  ovf_reg;

   logic [DATA_WIDTH-1:0] a_chunk;
   logic [DATA_WIDTH-1:0] b_chunk;
   logic [DATA_WIDTH-1:0] sum;
   logic                  cout;
   logic                  accept;
   logic                  last_chunk;

   assign a_chunk    = a_reg[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
   assign b_chunk    = b_reg[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
   assign accept     = (state == ADD_ST_IDLE) && i_req_valid;
   assign last_chunk = (idx == LAST_IDX);

   adder_xbit_serial #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_adder (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry),
      .sum  (sum),
      .cout (cout)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ADD_ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ADD_ST_IDLE: if (i_req_valid) state_next = ADD_ST_RUN;
         ADD_ST_RUN:  if (last_chunk)  state_next = ADD_ST_DONE;
         ADD_ST_DONE: if (i_res_ready) state_next = ADD_ST_IDLE;
         default:     state_next = ADD_ST_IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1, so b is inverted once at accept time.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         idx     <= '0;
         carry   <= 1'b0;
         a_reg   <= '0;
         b_reg   <= '0;
         res     <= '0;
         cry_reg <= 1'b0;
         ovf_reg <= 1'b0;
      end else if (accept) begin
         a_reg   <= i_num_a;
         b_reg   <= i_sub ? ~i_num_b : i_num_b;
         carry   <= i_sub | i_cry;
         idx     <= '0;
         res     <= '0;
         cry_reg <= 1'b0;
         ovf_reg <= 1'b0;
      end else if (state == ADD_ST_RUN) begin
         res[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= sum;
         carry <= cout;
         if (last_chunk) begin
            idx     <= '0;
            cry_reg <= cout;
            ovf_reg <= (a_chunk[DATA_WIDTH-1] == b_chunk[DATA_WIDTH-1]) &&
                       (sum[DATA_WIDTH-1] != a_chunk[DATA_WIDTH-1]);
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign o_req_ready = (state == ADD_ST_IDLE);
   assign o_res_valid = (state == ADD_ST_DONE);
   assign o_res       = res;
   assign o_cry       = cry_reg;
   assign o_ovf       = ovf_reg;

endmodule
